// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: unsigned or two's-complement, one multiplier bit per clock.
// Latency: done pulses WIDTH+2 edges after start is sampled (fixed; no early termination).
// Backpressure: none; start is accepted only in IDLE, and while busy it is ignored.
module seq_shift_add_multiplier #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     multiplicand_in,
   input  logic [WIDTH-1:0]     multiplier_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product_out
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 neg_q, neg_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic                 sign_flag;
   logic [WIDTH-1:0]     mcand_mag;
   logic [WIDTH-1:0]     mplier_mag;
   logic [WIDTH:0]       add_term;
   logic [WIDTH:0]       sum;

   // Next-state logic: operand capture as magnitudes, one add/shift step per cycle, sign fix-up at the end.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      count_d   = count_q;
      neg_d     = neg_q;
      product_d = product_q;
      done_d    = 1'b0;

      // The most negative value negates to itself, which read unsigned is exactly its magnitude.
      sign_flag  = is_signed & SIGNED_EN;
      mcand_mag  = (sign_flag && multiplicand_in[WIDTH-1]) ? -multiplicand_in : multiplicand_in;
      mplier_mag = (sign_flag && multiplier_in[WIDTH-1])   ? -multiplier_in   : multiplier_in;

      // Upper-half accumulate kept one bit wider so the carry shifts into the product.
      add_term = prod_q[0] ? {1'b0, mcand_q} : '0;
      sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + add_term;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = mcand_mag;
               neg_d   = sign_flag & (multiplicand_in[WIDTH-1] ^ multiplier_in[WIDTH-1]);
               prod_d  = {{WIDTH{1'b0}}, mplier_mag};
               count_d = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            prod_d  = {sum, prod_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            // Negating zero yields zero, so a zero operand needs no special case.
            product_d = neg_q ? -prod_q : prod_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         prod_q    <= '0;
         count_q   <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
         count_q   <= count_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign product_out = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for the shift-add multiplier at WIDTH=8 and WIDTH=32 (signed and unsigned-only).
// Latency: checks done arrives exactly WIDTH+2 edges after start, counting the sampling edge.
// Backpressure: exercises start ignored while busy and start accepted in the done cycle.
module tb_seq_shift_add_multiplier;

   logic        clk;
   logic        reset;

   logic        st8, sg8;
   logic [7:0]  a8, b8;
   logic        busy8, done8;
   logic [15:0] p8;

   logic        st32, sg32;
   logic [31:0] a32, b32;
   logic        busy32s, done32s, busy32u, done32u;
   logic [63:0] p32s, p32u;

   int checks;
   int failures;

   seq_shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
      .clk(clk), .reset(reset), .start(st8), .is_signed(sg8),
      .multiplicand_in(a8), .multiplier_in(b8),
      .busy(busy8), .done(done8), .product_out(p8)
   );

   seq_shift_add_multiplier #(.WIDTH(32), .SIGNED_EN(1'b1)) u32s (
      .clk(clk), .reset(reset), .start(st32), .is_signed(sg32),
      .multiplicand_in(a32), .multiplier_in(b32),
      .busy(busy32s), .done(done32s), .product_out(p32s)
   );

   seq_shift_add_multiplier #(.WIDTH(32), .SIGNED_EN(1'b0)) u32u (
      .clk(clk), .reset(reset), .start(st32), .is_signed(sg32),
      .multiplicand_in(a32), .multiplier_in(b32),
      .busy(busy32u), .done(done32u), .product_out(p32u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one 8-bit request, then waits for done and checks latency, busy and product.
   task automatic do_op8(input string tag, input logic sg, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp);
      int n;
      logic bad;
      sg8 = sg; a8 = a; b8 = b; st8 = 1'b1;
      step();
      n = 1;
      st8 = 1'b0;
      bad = 1'b0;
      while (n < 30) begin
         step();
         n++;
         if (done8 === 1'b1) break;
         if (busy8 !== 1'b1) bad = 1'b1;
      end
      chk({tag, "_latency"}, 64'(n), 64'd10);
      chk({tag, "_busy"}, 64'(bad), 64'd0);
      chk({tag, "_product"}, 64'(p8), 64'(exp));
   endtask

   // Drives the same request into both 32-bit instances and checks both results.
   task automatic do_op32(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_s, input logic [63:0] exp_u);
      int n, ns, nu;
      logic [63:0] rs, ru;
      sg32 = sg; a32 = a; b32 = b; st32 = 1'b1;
      step();
      n = 1; ns = 0; nu = 0; rs = '0; ru = '0;
      st32 = 1'b0;
      while (n < 60 && (ns == 0 || nu == 0)) begin
         step();
         n++;
         if (done32s === 1'b1 && ns == 0) begin ns = n; rs = p32s; end
         if (done32u === 1'b1 && nu == 0) begin nu = n; ru = p32u; end
      end
      chk({tag, "_s_latency"}, 64'(ns), 64'd34);
      chk({tag, "_s_product"}, rs, exp_s);
      chk({tag, "_u_latency"}, 64'(nu), 64'd34);
      chk({tag, "_u_product"}, ru, exp_u);
   endtask

   initial begin
      int n;
      logic bad;
      checks = 0;
      failures = 0;
      reset = 1'b0;
      st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
      st32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;

      // Reset state
      step();
      step();
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_product", 64'(p8), 64'd0);
      chk("rst_product32", p32s, 64'd0);
      reset = 1'b1;
      step();

      // 1: unsigned max*max
      do_op8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
      step();
      chk("done_pulse_width", 64'(done8), 64'd0);
      chk("product_hold", 64'(p8), 64'hFE01);

      // 2: signed corner cases and is_signed=0 on a negative-looking operand
      do_op8("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
      do_op8("s_m128_127", 1'b1, 8'h80, 8'h7F, 16'hC080);
      do_op8("u_80_02", 1'b0, 8'h80, 8'h02, 16'h0100);
      do_op8("u_zero", 1'b0, 8'h00, 8'hFF, 16'h0000);
      do_op8("s_neg_zero", 1'b1, 8'hFF, 8'h00, 16'h0000);

      // 3: start re-pulsed at iterations 2 and 5 with other operands must be ignored
      sg8 = 1'b0; a8 = 8'h0D; b8 = 8'h0B; st8 = 1'b1;
      step();
      n = 1;
      st8 = 1'b0;
      bad = 1'b0;
      while (n < 30) begin
         step();
         n++;
         if (done8 === 1'b1) break;
         if (busy8 !== 1'b1) bad = 1'b1;
         if (n == 3) begin
            st8 = 1'b1; sg8 = 1'b1; a8 = 8'hFF; b8 = 8'h80;
         end else if (n == 6) begin
            st8 = 1'b1; sg8 = 1'b0; a8 = 8'h33; b8 = 8'h44;
         end else begin
            st8 = 1'b0;
         end
      end
      chk("ignore_latency", 64'(n), 64'd10);
      chk("ignore_busy", 64'(bad), 64'd0);
      chk("ignore_product", 64'(p8), 64'h008F);

      // 4: back-to-back, start asserted in the done cycle
      do_op8("b2b_3_5", 1'b0, 8'h03, 8'h05, 16'h000F);

      // 5: asynchronous reset mid-CALC, then a fresh operation
      sg8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; st8 = 1'b1;
      step();
      st8 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("midop_busy_before", 64'(busy8), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", 64'(busy8), 64'd0);
      chk("arst_done", 64'(done8), 64'd0);
      chk("arst_product", 64'(p8), 64'd0);
      step();
      chk("arst_held_busy", 64'(busy8), 64'd0);
      reset = 1'b1;
      step();
      do_op8("post_rst_7_9", 1'b0, 8'h07, 8'h09, 16'h003F);

      // 6/7: 32-bit, with and without signed support
      do_op32("w32_unsigned", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
              64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001);
      do_op32("w32_signed", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
              64'h0000000000000001, 64'hFFFFFFFE00000001);
      do_op32("w32_sgn_mixed", 1'b1, 32'hFFFFFFFE, 32'h00000003,
              64'hFFFFFFFFFFFFFFFA, 64'h00000002FFFFFFFA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
